// File: rtl/mmu_result_collector.sv
// Collects the four staggered column streams of the 4x4 systolic array into two
// ping-pong matrix banks and drains each complete matrix as a 16-beat AXI4-Stream burst.
module mmu_result_collector #(
    parameter int DATA_W    = 32,
    parameter bit ROW_MAJOR = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [DATA_W-1:0] i_data3,
    input  logic [DATA_W-1:0] i_data4,
    input  logic              i_valid1,
    input  logic              i_valid2,
    input  logic              i_valid3,
    input  logic              i_valid4,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              o_busy,
    output logic              o_overflow,
    input  logic              i_ovf_clr
);

    logic [DATA_W-1:0] col_data [4];
    logic [3:0]        col_valid;

    logic [DATA_W-1:0] mem [2][4][4];
    logic [1:0]        full;
    logic              wb;
    logic              rb;
    logic              discard;
    logic [1:0]        wcnt [4];
    logic [3:0]        col_done;
    logic [3:0]        k;

    logic       hs;
    logic       last_hs;
    logic       writable;
    logic       first_word;
    logic       discard_eff;
    logic [3:0] done_next;
    logic       matrix_done;
    logic       set_full;
    logic       nb;
    logic [3:0] nk;
    logic       avail;
    logic [1:0] n_row;
    logic [1:0] n_col;

    assign col_data[0] = i_data1;
    assign col_data[1] = i_data2;
    assign col_data[2] = i_data3;
    assign col_data[3] = i_data4;
    assign col_valid   = {i_valid4, i_valid3, i_valid2, i_valid1};

    always_comb begin
        hs          = m_axis_tvalid & m_axis_tready;
        last_hs     = hs & (k == 4'd15);
        // The bank being drained can be refilled on the very cycle its last beat leaves.
        writable    = ~full[wb] | (last_hs & (rb == wb));
        first_word  = (|col_valid) & ~(|col_done);
        done_next   = '0;
        o_busy      = |full;
        for (int unsigned j = 0; j < 4; j++) begin
            first_word             = first_word & (wcnt[j[1:0]] == 2'd0);
            done_next[j[1:0]]      = col_done[j[1:0]] | (col_valid[j[1:0]] & (wcnt[j[1:0]] == 2'd3));
            o_busy                 = o_busy | (wcnt[j[1:0]] != 2'd0);
        end
        discard_eff = discard | (first_word & ~writable);
        matrix_done = &done_next;
        set_full    = matrix_done & ~discard_eff;

        // Beat that the output register presents after this edge.
        if (last_hs) begin
            nb = ~rb;
            nk = '0;
        end else if (hs) begin
            nb = rb;
            nk = k + 4'd1;
        end else begin
            nb = rb;
            nk = k;
        end
        avail = full[nb] | (set_full & (wb == nb));
        n_row = ROW_MAJOR ? nk[3:2] : nk[1:0];
        n_col = ROW_MAJOR ? nk[1:0] : nk[3:2];
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned j = 0; j < 4; j++) begin
            if (col_valid[j[1:0]] && !discard_eff)
                mem[wb][wcnt[j[1:0]]][j[1:0]] <= col_data[j[1:0]];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full          <= '0;
            wb            <= 1'b0;
            rb            <= 1'b0;
            discard       <= 1'b0;
            col_done      <= '0;
            k             <= '0;
            for (int unsigned j = 0; j < 4; j++)
                wcnt[j[1:0]] <= '0;
            o_overflow    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (col_valid[j[1:0]])
                    wcnt[j[1:0]] <= wcnt[j[1:0]] + 2'd1;
            end

            if (last_hs) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
                k        <= '0;
            end else if (hs) begin
                k <= k + 4'd1;
            end

            if (matrix_done) begin
                col_done <= '0;
                discard  <= 1'b0;
                if (set_full) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                end
            end else begin
                col_done <= done_next;
                discard  <= discard_eff;
            end

            if (first_word && !writable)
                o_overflow <= 1'b1;
            else if (i_ovf_clr)
                o_overflow <= 1'b0;

            if (!m_axis_tvalid || hs) begin
                m_axis_tvalid <= avail;
                m_axis_tlast  <= avail & (nk == 4'd15);
                m_axis_tdata  <= avail ? mem[nb][n_row][n_col] : '0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_result_collector.sv
// Bench for mmu_result_collector: row-major and column-major instances share one stimulus
// stream and are checked against a matrix-level queue model of the collector.
module tb_mmu_result_collector;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int nmat;
        int mode;       // 0: tready=1, 1: 1,0,0,1 pattern, 2: 0 while sending then 1, 3: random
        bit b2b;
        bit rnd;
        int exp_beats;  // -1: from model
        int exp_ovf;    // -1: from model
        bit contig;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din [4];
    logic [3:0]  vin = '0;
    logic        tready = 1'b1;
    logic        ovf_clr = 1'b0;

    logic [31:0] tdata_r, tdata_c;
    logic        tvalid_r, tvalid_c, tlast_r, tlast_c, busy_r, busy_c, ovf_r, ovf_c;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    beat_t q_r[$];
    beat_t q_c[$];
    int    held = 0;
    int    acc = 0;
    bit    ovf_exp = 0;
    int    mat_id = 0;
    int    last_valid_cyc = 0;
    int    ready_mode = 0;

    int          hs_cnt [2];
    int          rise_cyc [2];
    int          first_hs [2];
    int          last_hs [2];
    logic        tv_p [2];
    logic        stall_p [2];
    logic [31:0] data_p [2];
    logic        last_p [2];

    vec_t vt [6];
    logic pat [4];

    mmu_result_collector #(.DATA_W(32), .ROW_MAJOR(1'b1)) dut_r (
        .i_clk(clk), .i_rst(rst),
        .i_data1(din[0]), .i_data2(din[1]), .i_data3(din[2]), .i_data4(din[3]),
        .i_valid1(vin[0]), .i_valid2(vin[1]), .i_valid3(vin[2]), .i_valid4(vin[3]),
        .m_axis_tdata(tdata_r), .m_axis_tvalid(tvalid_r), .m_axis_tready(tready),
        .m_axis_tlast(tlast_r), .o_busy(busy_r), .o_overflow(ovf_r), .i_ovf_clr(ovf_clr)
    );

    mmu_result_collector #(.DATA_W(32), .ROW_MAJOR(1'b0)) dut_c (
        .i_clk(clk), .i_rst(rst),
        .i_data1(din[0]), .i_data2(din[1]), .i_data3(din[2]), .i_data4(din[3]),
        .i_valid1(vin[0]), .i_valid2(vin[1]), .i_valid3(vin[2]), .i_valid4(vin[3]),
        .m_axis_tdata(tdata_c), .m_axis_tvalid(tvalid_c), .m_axis_tready(tready),
        .m_axis_tlast(tlast_c), .o_busy(busy_c), .o_overflow(ovf_c), .i_ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic tv, input logic tr, input logic [31:0] td, input logic tl);
        beat_t e;
        if (stall_p[d]) begin
            check(d == 0 ? "stall_tvalid_r" : "stall_tvalid_c", tv, 1);
            check(d == 0 ? "stall_tdata_r" : "stall_tdata_c", td, data_p[d]);
            check(d == 0 ? "stall_tlast_r" : "stall_tlast_c", tl, last_p[d]);
        end
        if (tv && !tv_p[d] && rise_cyc[d] < 0)
            rise_cyc[d] = cyc;
        if (tv && tr) begin
            if ((d == 0 && q_r.size() == 0) || (d == 1 && q_c.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat dut%0d: got %0h expected no beat", d, td);
            end else begin
                if (d == 0) e = q_r.pop_front();
                else        e = q_c.pop_front();
                check(d == 0 ? "tdata_rowmajor" : "tdata_colmajor", td, e.data);
                check(d == 0 ? "tlast_rowmajor" : "tlast_colmajor", tl, e.last);
                if (d == 0 && e.last) held--;
            end
            hs_cnt[d]++;
            if (first_hs[d] < 0) first_hs[d] = cyc;
            last_hs[d] = cyc;
        end
        tv_p[d]    = tv;
        stall_p[d] = tv && !tr;
        data_p[d]  = td;
        last_p[d]  = tl;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, tvalid_r, tready, tdata_r, tlast_r);
            mon(1, tvalid_c, tready, tdata_c, tlast_c);
        end else begin
            for (int d = 0; d < 2; d++) begin
                tv_p[d]    = 1'b0;
                stall_p[d] = 1'b0;
            end
        end
    end

    initial begin
        int pc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                tready = pat[pc];
                pc = (pc + 1) % 4;
            end else if (ready_mode == 3) begin
                tready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            hs_cnt[d]   = 0;
            rise_cyc[d] = -1;
            first_hs[d] = -1;
            last_hs[d]  = -1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        vin = '0;
        ovf_clr = 1'b0;
        q_r.delete();
        q_c.delete();
        held = 0;
        acc = 0;
        ovf_exp = 0;
        mat_id = 0;
        #1;
        check("rst_tvalid_r", tvalid_r, 0);
        check("rst_tlast_r", tlast_r, 0);
        check("rst_tdata_r", tdata_r, 0);
        check("rst_busy_r", busy_r, 0);
        check("rst_ovf_r", ovf_r, 0);
        check("rst_tvalid_c", tvalid_c, 0);
        check("rst_busy_c", busy_c, 0);
        check("rst_ovf_c", ovf_c, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
    endtask

    // Sends one 4x4 matrix; column j carries rows 0..3 at per-column schedule times.
    task automatic send_matrix(input bit rnd, input bit b2b);
        int          sched [4][4];
        logic [31:0] w [4][4];
        int          tend = 0;
        int          tfirst = 1000;
        int          start;
        bit          any;
        for (int j = 0; j < 4; j++) begin
            start = rnd ? int'($urandom_range(0, 3)) : j;
            for (int r = 0; r < 4; r++) begin
                sched[j][r] = (r == 0) ? start : sched[j][r-1] + 1 + (rnd ? int'($urandom_range(0, 2)) : 0);
                if (sched[j][r] > tend) tend = sched[j][r];
            end
            if (start < tfirst) tfirst = start;
        end
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                w[r][j] = rnd ? $urandom : 32'((mat_id << 8) + 16 * r + j);
        for (int t = 0; t <= tend + (b2b ? 0 : 1); t++) begin
            @(posedge clk);
            #1;
            any = 0;
            for (int j = 0; j < 4; j++) begin
                vin[j] = 1'b0;
                for (int r = 0; r < 4; r++) begin
                    if (sched[j][r] == t) begin
                        vin[j] = 1'b1;
                        din[j] = w[r][j];
                        any = 1;
                    end
                end
            end
            if (any) last_valid_cyc = cyc;
            if (t == tfirst) begin
                // The first word claims a bank only if fewer than two matrices are still held.
                @(negedge clk);
                #1;
                if (held < 2) begin
                    held++;
                    acc++;
                    for (int b = 0; b < 16; b++) begin
                        q_r.push_back('{data: w[b / 4][b % 4], last: (b == 15)});
                        q_c.push_back('{data: w[b % 4][b / 4], last: (b == 15)});
                    end
                end else begin
                    ovf_exp = 1;
                end
            end
        end
        mat_id++;
    endtask

    task automatic wait_drain();
        int i = 0;
        while ((q_r.size() != 0 || q_c.size() != 0) && i < 3000) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("drain_remaining", q_r.size() + q_c.size(), 0);
    endtask

    initial begin
        int first_lv;
        int exp_beats;
        int i;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int j = 0; j < 4; j++) din[j] = '0;
        clear_stats();
        vt[0] = '{nmat: 1, mode: 0, b2b: 0, rnd: 0, exp_beats: 16, exp_ovf: 0, contig: 1};
        vt[1] = '{nmat: 1, mode: 1, b2b: 0, rnd: 0, exp_beats: 16, exp_ovf: 0, contig: 0};
        vt[2] = '{nmat: 2, mode: 0, b2b: 1, rnd: 0, exp_beats: 32, exp_ovf: 0, contig: 1};
        vt[3] = '{nmat: 3, mode: 2, b2b: 0, rnd: 0, exp_beats: 32, exp_ovf: 1, contig: 0};
        vt[4] = '{nmat: 6, mode: 3, b2b: 0, rnd: 1, exp_beats: -1, exp_ovf: -1, contig: 0};
        vt[5] = '{nmat: 6, mode: 3, b2b: 0, rnd: 1, exp_beats: -1, exp_ovf: -1, contig: 0};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            ready_mode = vt[v].mode;
            tready = (vt[v].mode == 2) ? 1'b0 : 1'b1;
            first_lv = 0;
            for (int m = 0; m < vt[v].nmat; m++) begin
                send_matrix(vt[v].rnd, vt[v].b2b && (m < vt[v].nmat - 1));
                if (m == 0) first_lv = last_valid_cyc;
                if (vt[v].rnd) repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            if (vt[v].mode == 2) begin
                @(posedge clk);
                #1;
                tready = 1'b1;
            end
            wait_drain();
            repeat (20) @(negedge clk);
            #1;
            exp_beats = (vt[v].exp_beats < 0) ? acc * 16 : vt[v].exp_beats;
            check("tvalid_rise_r", rise_cyc[0], first_lv + 1);
            check("tvalid_rise_c", rise_cyc[1], first_lv + 1);
            check("beats_r", hs_cnt[0], exp_beats);
            check("beats_c", hs_cnt[1], exp_beats);
            check("overflow_r", ovf_r, (vt[v].exp_ovf < 0) ? 1'(ovf_exp) : 1'(vt[v].exp_ovf));
            check("overflow_c", ovf_c, (vt[v].exp_ovf < 0) ? 1'(ovf_exp) : 1'(vt[v].exp_ovf));
            check("idle_busy_r", busy_r, 0);
            check("idle_tvalid_r", tvalid_r, 0);
            if (vt[v].contig)
                check("contiguous_beats", last_hs[0] - first_hs[0] + 1, exp_beats);
            if (vt[v].mode == 2) begin
                @(posedge clk);
                #1;
                ovf_clr = 1'b1;
                @(posedge clk);
                #1;
                ovf_clr = 1'b0;
                check("ovf_clear_r", ovf_r, 0);
                check("ovf_clear_c", ovf_c, 0);
            end
        end

        // Asynchronous reset in the middle of a drain, then a fresh matrix.
        do_reset();
        ready_mode = 0;
        tready = 1'b1;
        send_matrix(0, 0);
        i = 0;
        while (hs_cnt[0] < 5 && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("reached_beat5", hs_cnt[0] >= 5, 1);
        check("busy_mid_drain", busy_r, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_tvalid_r", tvalid_r, 0);
        check("async_tlast_r", tlast_r, 0);
        check("async_busy_r", busy_r, 0);
        check("async_tvalid_c", tvalid_c, 0);
        check("async_busy_c", busy_c, 0);
        q_r.delete();
        q_c.delete();
        held = 0;
        acc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        mat_id = 5;
        send_matrix(0, 0);
        wait_drain();
        repeat (10) @(negedge clk);
        check("post_reset_beats_r", hs_cnt[0], 16);
        check("post_reset_beats_c", hs_cnt[1], 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
